// File: rtl/stat_pipe_core.sv
// rtl/stat_pipe_core.sv - pipelined layers of mixed 4-input gates with valid/ready flow control and an output MISR
module stat_pipe_core #(
    parameter int             W      = 32,
    parameter int             STAGES = 3,
    parameter logic [W-1:0]   POLY   = W'(32'h04C11DB7)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    input  logic         sig_clr,
    output logic [W-1:0] sig,
    output logic [15:0]  xfer_cnt
);

    // Bit i of layer s uses taps i, i+1, i+3, i+7 (mod W); gate type rotates with i+s.
    function automatic logic [W-1:0] layer(input logic [W-1:0] d, input int s);
        logic [W-1:0] y;
        logic a, b, c, e;
        y = '0;
        for (int i = 0; i < W; i++) begin
            a = d[i];
            b = d[(i + 1) % W];
            c = d[(i + 3) % W];
            e = d[(i + 7) % W];
            case ((i + s) % 6)
                0:       y[i] = a & b & c & e;
                1:       y[i] = ~(a & b & c & e);
                2:       y[i] = a | b | c | e;
                3:       y[i] = ~(a | b | c | e);
                4:       y[i] = a ^ b ^ c ^ e;
                default: y[i] = ~(a ^ b ^ c ^ e);
            endcase
        end
        return y;
    endfunction

    logic [W-1:0]    dat  [1:STAGES];
    logic [W-1:0]    nxt  [1:STAGES];
    logic [STAGES:1] v;
    logic [STAGES:1] vprev;
    logic [STAGES:1] adv;
    logic            xfer;

    // A stage may advance when anything downstream of it (or the sink) can take a word.
    always_comb begin
        logic free;
        free = out_ready;
        for (int s = STAGES; s >= 1; s--) begin
            free   = free | ~v[s];
            adv[s] = free;
        end
    end

    always_comb begin
        nxt[1]   = layer(in_data, 1);
        vprev[1] = in_valid;
        for (int s = 2; s <= STAGES; s++) begin
            nxt[s]   = layer(dat[s-1], s);
            vprev[s] = v[s-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
            for (int s = 1; s <= STAGES; s++) dat[s] <= '0;
        end else begin
            for (int s = 1; s <= STAGES; s++) begin
                if (adv[s]) begin
                    dat[s] <= nxt[s];
                    v[s]   <= vprev[s];
                end
            end
        end
    end

    assign in_ready  = ~rst & adv[1];
    assign out_valid = v[STAGES];
    assign out_data  = dat[STAGES];
    assign xfer      = out_valid & out_ready;

    // A clear wins over a coincident transfer; the word still leaves the pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig      <= '0;
            xfer_cnt <= '0;
        end else if (sig_clr) begin
            sig      <= '0;
            xfer_cnt <= '0;
        end else if (xfer) begin
            sig      <= {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : '0) ^ out_data;
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end

endmodule
